// File: rtl/div_sequencer.sv
// Division controller: repeated subtraction on the shared ALU/mux/register-file datapath.
// Emits the 15-bit control word {alu, mux_a, mux_b, reg, w} and a start/done handshake.
module div_sequencer #(
    parameter int          ITER_W   = 8,
    parameter int          MAX_ITER = 255,
    parameter logic [1:0]  ALU_ADD  = 2'b00,
    parameter logic [1:0]  ALU_SUB  = 2'b01,
    parameter logic [3:0]  R_ZERO   = 4'd0,
    parameter logic [3:0]  R_DVD    = 4'd1,
    parameter logic [3:0]  R_DVS    = 4'd2,
    parameter logic [3:0]  R_QUO    = 4'd3,
    parameter logic [3:0]  R_ONE    = 4'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mayor,
    input  logic              bandera,
    input  logic              zero,
    output logic [14:0]       o_signal,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLRQ,
        S_CHKZ,
        S_CMP,
        S_SUB,
        S_INC,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [ITER_W-1:0]   iter_inc;

    function automatic logic [14:0] cw(
        input logic [1:0] alu,
        input logic [3:0] ma,
        input logic [3:0] mb,
        input logic [3:0] rg,
        input logic       w
    );
        return {alu, ma, mb, rg, w};
    endfunction

    assign iter_inc = iter_q + 1'b1;
    assign iter_cnt = iter_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        o_signal = '0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLRQ;
                    iter_d  = '0;
                end
            end
            S_CLRQ: begin
                busy     = 1'b1;
                o_signal = cw(ALU_SUB, R_QUO, R_QUO, R_QUO, 1'b1);
                state_d  = S_CHKZ;
            end
            S_CHKZ: begin
                busy     = 1'b1;
                o_signal = cw(ALU_SUB, R_DVS, R_ZERO, 4'd0, 1'b0);
                state_d  = zero ? S_ERR : S_CMP;
            end
            S_CMP: begin
                busy     = 1'b1;
                o_signal = cw(ALU_SUB, R_DVD, R_DVS, 4'd0, 1'b0);
                state_d  = (mayor | bandera) ? S_SUB : S_DONE;
            end
            S_SUB: begin
                busy     = 1'b1;
                o_signal = cw(ALU_SUB, R_DVD, R_DVS, R_DVD, 1'b1);
                state_d  = S_INC;
            end
            S_INC: begin
                busy     = 1'b1;
                o_signal = cw(ALU_ADD, R_QUO, R_ONE, R_QUO, 1'b1);
                iter_d   = iter_inc;
                // Overflow is caught before the counter can wrap.
                state_d  = (iter_inc == ITER_W'(MAX_ITER)) ? S_ERR : S_CMP;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: two instances (MAX_ITER 255 and 4) on a modelled datapath,
// checked every cycle against a timing/arithmetic model of the division.
module tb_div_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_v [2];
    logic        ld_en   [2];
    logic [15:0] ld_dvd  [2];
    logic [15:0] ld_dvs  [2];
    logic [14:0] osig    [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        err_w   [2];
    logic [7:0]  itc     [2];

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [14:0] W_CLRQ = {2'b01, 4'd3, 4'd3, 4'd3, 1'b1};
    localparam logic [14:0] W_CHKZ = {2'b01, 4'd2, 4'd0, 4'd0, 1'b0};
    localparam logic [14:0] W_CMP  = {2'b01, 4'd1, 4'd2, 4'd0, 1'b0};
    localparam logic [14:0] W_SUB  = {2'b01, 4'd1, 4'd2, 4'd1, 1'b1};
    localparam logic [14:0] W_INC  = {2'b00, 4'd3, 4'd4, 4'd3, 1'b1};

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Arithmetic model of one division.
    function automatic int f_q(input int dvd, input int dvs, input int mx);
        if (dvs == 0) return 0;
        return (dvd / dvs >= mx) ? mx : dvd / dvs;
    endfunction

    function automatic bit f_err(input int dvd, input int dvs, input int mx);
        return (dvs == 0) || (dvd / dvs >= mx);
    endfunction

    function automatic int f_lat(input int dvd, input int dvs, input int mx);
        if (dvs == 0) return 3;
        if (dvd / dvs >= mx) return 3 * mx + 3;
        return 3 * (dvd / dvs) + 4;
    endfunction

    function automatic int f_rem(input int dvd, input int dvs, input int mx);
        return dvd - f_q(dvd, dvs, mx) * dvs;
    endfunction

    // Control word expected t edges into an operation of length l.
    function automatic logic [14:0] f_os(input int t, input int l);
        if (t == 0 || t == l) return 15'd0;
        if (t == 1) return W_CLRQ;
        if (t == 2) return W_CHKZ;
        case ((t - 3) % 3)
            0:       return W_CMP;
            1:       return W_SUB;
            default: return W_INC;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int MX = (g == 0) ? 255 : 4;

        logic        mayor, bandera, zero;
        logic [15:0] rf [16];
        logic [15:0] ma, mb, alu;
        int          wcnt = 0;

        div_sequencer #(.MAX_ITER(MX)) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_v[g]),
            .mayor    (mayor),
            .bandera  (bandera),
            .zero     (zero),
            .o_signal (osig[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .err      (err_w[g]),
            .iter_cnt (itc[g])
        );

        always_comb begin
            ma      = rf[osig[g][12:9]];
            mb      = rf[osig[g][8:5]];
            alu     = (osig[g][14:13] == 2'b00) ? ma + mb : ma - mb;
            mayor   = ma > mb;
            bandera = ma == mb;
            zero    = alu == 16'd0;
        end

        always @(posedge clk) begin
            if (ld_en[g]) begin
                for (int i = 0; i < 16; i++) rf[i] <= 16'd0;
                rf[1] <= ld_dvd[g];
                rf[2] <= ld_dvs[g];
                rf[3] <= 16'h00AA;
                rf[4] <= 16'd1;
            end else if (osig[g][0]) begin
                rf[osig[g][4:1]] <= alu;
                wcnt <= wcnt + 1;
            end
        end

        // Model: edges elapsed since the accepted start, and the outcome.
        int          m_t = 0, m_l = 0, m_q = 0, m_it = 0;
        bit          m_e = 1'b0;
        int          m_rem = 0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_t  <= 0;
                m_it <= 0;
            end else if (m_t == 0) begin
                if (start_v[g]) begin
                    m_t   <= 1;
                    m_it  <= 0;
                    m_l   <= f_lat(int'(rf[1]), int'(rf[2]), MX);
                    m_e   <= f_err(int'(rf[1]), int'(rf[2]), MX);
                    m_q   <= f_q(int'(rf[1]), int'(rf[2]), MX);
                    m_rem <= f_rem(int'(rf[1]), int'(rf[2]), MX);
                end
            end else if (m_t == m_l) begin
                m_t <= 0;
            end else begin
                m_t <= m_t + 1;
                if (m_t >= 5 && (m_t - 5) % 3 == 0) m_it <= m_it + 1;
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                chk($sformatf("i%0d_busy t=%0d", g, m_t), busy_w[g],
                    (m_t >= 1 && m_t < m_l) ? 1 : 0);
                chk($sformatf("i%0d_done t=%0d", g, m_t), done_w[g],
                    (m_t != 0 && m_t == m_l) ? 1 : 0);
                chk($sformatf("i%0d_err t=%0d", g, m_t), err_w[g],
                    (m_t != 0 && m_t == m_l && m_e) ? 1 : 0);
                chk($sformatf("i%0d_iter t=%0d", g, m_t), itc[g], m_it);
                chk($sformatf("i%0d_osig t=%0d", g, m_t), osig[g], f_os(m_t, m_l));
                if (m_t != 0 && m_t == m_l) begin
                    chk($sformatf("i%0d_dvd_reg", g), rf[1], m_rem);
                    chk($sformatf("i%0d_quo_reg", g), rf[3], m_q);
                end
            end
        end
    end

    task automatic load(input int g, input int dvd, input int dvs);
        @(negedge clk);
        ld_dvd[g] = 16'(dvd);
        ld_dvs[g] = 16'(dvs);
        ld_en[g]  = 1'b1;
        @(negedge clk);
        ld_en[g]  = 1'b0;
    endtask

    task automatic run(input int g, input int dvd, input int dvs, input int poke,
                       input int e_lat, input int e_it, input bit e_err);
        int n;
        load(g, dvd, dvs);
        start_v[g] = 1'b1;
        @(negedge clk);
        n = 1;
        while (!done_w[g] && n < 2000) begin
            start_v[g] = (n == poke);
            @(negedge clk);
            n++;
        end
        start_v[g] = 1'b0;
        chk($sformatf("run%0d %0d/%0d latency", g, dvd, dvs), n, e_lat);
        chk($sformatf("run%0d %0d/%0d iter_cnt", g, dvd, dvs), itc[g], e_it);
        chk($sformatf("run%0d %0d/%0d err", g, dvd, dvs), err_w[g], e_err);
        chk($sformatf("run%0d %0d/%0d busy_at_done", g, dvd, dvs), busy_w[g], 0);
        @(negedge clk);
        chk($sformatf("run%0d done_pulse_width", g), done_w[g], 0);
        chk($sformatf("run%0d iter_hold", g), itc[g], e_it);
    endtask

    initial begin
        int w0, n, dvd, dvs, g, mx;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            ld_en[i]   = 1'b0;
            ld_dvd[i]  = 16'd0;
            ld_dvs[i]  = 16'd0;
        end
        repeat (2) @(negedge clk);
        chk("reset_osig", osig[0], 0);
        chk("reset_busy", busy_w[0], 0);
        chk("reset_done", done_w[0], 0);
        chk("reset_err", err_w[0], 0);
        chk("reset_iter", itc[0], 0);
        #1 rst = 1'b0;

        chk("pin_lat_13_4", f_lat(13, 4, 255), 13);
        chk("pin_q_13_4", f_q(13, 4, 255), 3);
        chk("pin_rem_13_4", f_rem(13, 4, 255), 1);
        chk("pin_lat_3_5", f_lat(3, 5, 255), 4);
        chk("pin_lat_8_8", f_lat(8, 8, 255), 7);
        chk("pin_lat_20_1_m4", f_lat(20, 1, 4), 15);
        chk("pin_rem_20_1_m4", f_rem(20, 1, 4), 16);
        chk("pin_lat_dvz", f_lat(7, 0, 255), 3);

        run(0, 13, 4, 0, 13, 3, 1'b0);
        chk("t13_4_dvd", gi[0].rf[1], 1);
        chk("t13_4_quo", gi[0].rf[3], 3);
        run(0, 3, 5, 0, 4, 0, 1'b0);
        chk("t3_5_quo", gi[0].rf[3], 0);
        chk("t3_5_dvd", gi[0].rf[1], 3);
        run(0, 8, 8, 0, 7, 1, 1'b0);
        chk("t8_8_quo", gi[0].rf[3], 1);
        chk("t8_8_dvd", gi[0].rf[1], 0);

        w0 = gi[0].wcnt;
        run(0, 7, 0, 0, 3, 0, 1'b1);
        chk("dvz_single_write", gi[0].wcnt - w0, 1);

        run(1, 20, 1, 0, 15, 4, 1'b1);
        chk("ovf_dvd", gi[1].rf[1], 16);
        chk("ovf_quo", gi[1].rf[3], 4);

        run(0, 13, 4, 4, 13, 3, 1'b0);
        chk("poke_dvd", gi[0].rf[1], 1);

        load(0, 13, 4);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_osig", osig[0], 0);
        chk("rst_async_busy", busy_w[0], 0);
        chk("rst_async_done", done_w[0], 0);
        chk("rst_async_iter", itc[0], 0);
        @(negedge clk);
        #1 rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(done_w[0]);
        end
        chk("rst_no_done", n, 0);
        run(0, 9, 2, 0, 16, 4, 1'b0);

        load(0, 10, 3);
        start_v[0] = 1'b1;
        repeat (30) @(negedge clk);
        start_v[0] = 1'b0;
        repeat (20) @(negedge clk);

        for (int k = 0; k < 40; k++) begin
            g   = int'($urandom_range(0, 1));
            mx  = (g == 0) ? 255 : 4;
            dvd = int'($urandom_range(0, 300));
            dvs = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            run(g, dvd, dvs, 0, f_lat(dvd, dvs, mx), f_q(dvd, dvs, mx),
                f_err(dvd, dvs, mx));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
